// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Captures memory-stage results, extracts and extends load data, drives the
// register file write port one cycle later and counts retired instructions.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [1:0]  mem_wb_sel,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_imm,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  Wt_addr,
    output logic [31:0] Wt_data,
    output logic        RegWrite,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] retired_count
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]  byte_off;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;
    logic [31:0] wb_data_next;
    logic        reg_write_next;
    logic [31:0] retire_q;

    assign byte_off = mem_alu_result[1:0];

    // Pick the addressed byte and halfword out of the aligned memory word
    always_comb begin
        load_byte = mem_rdata[7:0];
        case (byte_off)
            2'd0: load_byte = mem_rdata[7:0];
            2'd1: load_byte = mem_rdata[15:8];
            2'd2: load_byte = mem_rdata[23:16];
            2'd3: load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase
        // a[0] is ignored for halfword loads; misaligned halves are not split
        load_half = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Sign- or zero-extend according to load width; unknown widths act as LW
    always_comb begin
        load_data = mem_rdata;
        case (mem_funct3)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LBU:  load_data = {24'd0, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LHU:  load_data = {16'd0, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    assign pc_plus4 = mem_pc + 32'd4;

    // Writeback source select
    always_comb begin
        wb_data_next = mem_alu_result;
        case (mem_wb_sel)
            SEL_ALU:  wb_data_next = mem_alu_result;
            SEL_LOAD: wb_data_next = load_data;
            SEL_PC4:  wb_data_next = pc_plus4;
            SEL_IMM:  wb_data_next = mem_imm;
            default:  wb_data_next = mem_alu_result;
        endcase
    end

    // x0 is never written, but address and data are still captured
    assign reg_write_next = mem_valid & mem_reg_write & (mem_rd != 5'd0);

    // MEM/WB register: stall holds, flush inserts a bubble, otherwise capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_pc    <= RESET_PC;
            Wt_addr  <= 5'd0;
            Wt_data  <= 32'd0;
            RegWrite <= 1'b0;
        end else if (!stall_in) begin
            if (flush_in) begin
                wb_valid <= 1'b0;
                wb_pc    <= mem_pc;
                Wt_addr  <= 5'd0;
                Wt_data  <= 32'd0;
                RegWrite <= 1'b0;
            end else begin
                wb_valid <= mem_valid;
                wb_pc    <= mem_pc;
                Wt_addr  <= mem_rd;
                Wt_data  <= wb_data_next;
                RegWrite <= reg_write_next;
            end
        end
    end

    // Retire counter: the WB instruction retires when it leaves an unstalled stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= 32'd0;
        end else if (!stall_in && wb_valid) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retired_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a behavioural writeback model, a small
// register file with write-through read, and literal expectations per step.
module tb_wb_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam int K_NONE = 0;
    localparam int K_DATA = 1;
    localparam int K_PC   = 2;
    localparam int K_CNT  = 3;
    localparam int K_WE   = 4;
    localparam int K_RF1  = 5;
    localparam int K_RF2  = 6;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        flush_in;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_imm;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;
    logic        RegWrite;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] retired_count;

    wb_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
        .mem_alu_result(mem_alu_result), .mem_imm(mem_imm),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .Wt_addr(Wt_addr), .Wt_data(Wt_data), .RegWrite(RegWrite),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .retired_count(retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    logic        m_we;
    logic [31:0] m_data;
    logic [31:0] m_cnt;
    logic        preload;

    function automatic logic [31:0] expected_data(
        input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] alu,
        input logic [31:0] imm, input logic [2:0] f3, input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * alu[1:0])) & 32'hFF;
        h = (rdata >> (16 * alu[1])) & 32'hFFFF;
        if (sel == 2'b00) return alu;
        if (sel == 2'b10) return pc + 32'd4;
        if (sel == 2'b11) return imm;
        if (f3 == 3'b000) return b[7] ? (b | 32'hFFFF_FF00) : b;
        if (f3 == 3'b100) return b;
        if (f3 == 3'b001) return h[15] ? (h | 32'hFFFF_0000) : h;
        if (f3 == 3'b101) return h;
        return rdata;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_pc    <= RST_PC;
            m_rd    <= 5'd0;
            m_we    <= 1'b0;
            m_data  <= 32'd0;
            m_cnt   <= 32'd0;
        end else if (!stall_in) begin
            m_cnt <= (preload ? 32'hFFFF_FFFF : m_cnt) + (m_valid ? 32'd1 : 32'd0);
            m_pc  <= mem_pc;
            if (flush_in) begin
                m_valid <= 1'b0;
                m_rd    <= 5'd0;
                m_we    <= 1'b0;
                m_data  <= 32'd0;
            end else begin
                m_valid <= mem_valid;
                m_rd    <= mem_rd;
                m_we    <= mem_valid && mem_reg_write && (mem_rd != 5'd0);
                m_data  <= expected_data(mem_wb_sel, mem_pc, mem_alu_result,
                                         mem_imm, mem_funct3, mem_rdata);
            end
        end
    end

    // Register file fed by the DUT write port
    logic [31:0] rf [32];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (RegWrite) begin
            rf[Wt_addr] <= Wt_data;
        end
    end

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (RegWrite && Wt_addr == a && a != 5'd0) return Wt_data;
        return rf[a];
    endfunction

    // ---------------- compare process ----------------
    int          n_total;
    int          n_bad;
    logic        chk_on;
    int          lit_kind;
    logic [31:0] lit_val;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
            cmp("wb_pc", wb_pc, m_pc);
            cmp("Wt_addr", {27'd0, Wt_addr}, {27'd0, m_rd});
            cmp("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
            cmp("Wt_data", Wt_data, m_data);
            cmp("retired_count", retired_count, m_cnt);
            case (lit_kind)
                K_DATA: cmp("lit Wt_data", Wt_data, lit_val);
                K_PC:   cmp("lit wb_pc", wb_pc, lit_val);
                K_CNT:  cmp("lit retired_count", retired_count, lit_val);
                K_WE:   cmp("lit RegWrite", {31'd0, RegWrite}, lit_val);
                K_RF1:  cmp("lit rf x1", rf_read(5'd1), lit_val);
                K_RF2:  cmp("lit rf x2", rf_read(5'd2), lit_val);
                default: ;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_mem(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                           input logic rw, input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] imm, input logic [2:0] f3,
                           input logic [31:0] rdata);
        mem_valid      = v;
        mem_pc         = pc;
        mem_rd         = rd;
        mem_reg_write  = rw;
        mem_wb_sel     = sel;
        mem_alu_result = alu;
        mem_imm        = imm;
        mem_funct3     = f3;
        mem_rdata      = rdata;
    endtask

    // Called at posedge+1; the next posedge captures, expectations apply after it
    task automatic step(input int k, input logic [31:0] v);
        @(posedge clk);
        #1;
        lit_kind = k;
        lit_val  = v;
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        n_total  = 0;
        n_bad    = 0;
        chk_on   = 1'b0;
        lit_kind = K_NONE;
        lit_val  = 32'd0;
        preload  = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;
        rst      = 1'b0;
        set_mem(1'b0, 32'd0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 32'd0);
        #1 rst = 1'b1;
        #1 chk_on = 1'b1;
        lit_kind = K_PC;
        lit_val  = RST_PC;
        #11 rst = 1'b0;
        @(posedge clk);
        #1;
        lit_kind = K_CNT;
        lit_val  = 32'd0;

        // load extraction, rd=5
        set_mem(1'b1, 32'h0000_0400, 5'd5, 1'b1, 2'b01, 32'h0000_1001, 32'd0, 3'b000, RD);
        step(K_DATA, 32'h0000_007F);
        set_mem(1'b1, 32'h0000_0404, 5'd5, 1'b1, 2'b01, 32'h0000_1003, 32'd0, 3'b000, RD);
        step(K_DATA, 32'hFFFF_FF80);
        set_mem(1'b1, 32'h0000_0408, 5'd5, 1'b1, 2'b01, 32'h0000_1002, 32'd0, 3'b100, RD);
        step(K_DATA, 32'h0000_00FF);
        set_mem(1'b1, 32'h0000_040C, 5'd5, 1'b1, 2'b01, 32'h0000_1002, 32'd0, 3'b001, RD);
        step(K_DATA, 32'hFFFF_80FF);
        set_mem(1'b1, 32'h0000_0410, 5'd5, 1'b1, 2'b01, 32'h0000_1000, 32'd0, 3'b101, RD);
        step(K_DATA, 32'h0000_7F01);
        set_mem(1'b1, 32'h0000_0414, 5'd5, 1'b1, 2'b01, 32'h0000_1003, 32'd0, 3'b010, RD);
        step(K_DATA, 32'h80FF_7F01);
        set_mem(1'b1, 32'h0000_0418, 5'd5, 1'b1, 2'b01, 32'h0000_1001, 32'd0, 3'b111, RD);
        step(K_DATA, 32'h80FF_7F01);
        set_mem(1'b1, 32'h0000_041C, 5'd5, 1'b1, 2'b01, 32'h0000_1003, 32'd0, 3'b001, RD);
        step(K_DATA, 32'hFFFF_80FF);

        // other sources and x0
        set_mem(1'b1, 32'hFFFF_FFFC, 5'd6, 1'b1, 2'b10, 32'h1, 32'd0, 3'd0, 32'd0);
        step(K_DATA, 32'h0000_0000);
        set_mem(1'b1, 32'h0000_0420, 5'd7, 1'b1, 2'b11, 32'h1, 32'h1234_5000, 3'd0, 32'd0);
        step(K_DATA, 32'h1234_5000);
        set_mem(1'b1, 32'h0000_0424, 5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'd0, 3'd0, 32'd0);
        step(K_WE, 32'd0);
        set_mem(1'b0, 32'h0000_0428, 5'd9, 1'b1, 2'b00, 32'h0000_0009, 32'd0, 3'd0, 32'd0);
        step(K_WE, 32'd0);
        // 11 valid instructions captured before the bubble; 11 have now retired
        step(K_CNT, 32'd11);

        // stall / flush
        set_mem(1'b1, 32'h0000_0200, 5'd3, 1'b1, 2'b00, 32'h0000_0055, 32'd0, 3'd0, 32'd0);
        step(K_DATA, 32'h0000_0055);
        set_mem(1'b1, 32'h0000_0300, 5'd4, 1'b1, 2'b00, 32'h0000_0AAA, 32'd0, 3'd0, 32'd0);
        stall_in = 1'b1;
        step(K_DATA, 32'h0000_0055);
        step(K_PC, 32'h0000_0200);
        step(K_CNT, 32'd11);
        flush_in = 1'b1;
        step(K_DATA, 32'h0000_0055);
        stall_in = 1'b0;
        step(K_WE, 32'd0);
        flush_in = 1'b0;
        step(K_CNT, 32'd12);

        // back-to-back with register file
        set_mem(1'b1, 32'h0000_0500, 5'd1, 1'b1, 2'b00, 32'd5, 32'd0, 3'd0, 32'd0);
        step(K_RF1, 32'd5);
        set_mem(1'b1, 32'h0000_0504, 5'd2, 1'b1, 2'b00, 32'd10, 32'd0, 3'd0, 32'd0);
        step(K_RF1, 32'd5);
        set_mem(1'b0, 32'h0000_0508, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 32'd0);
        step(K_RF2, 32'd10);

        // counter wrap
        set_mem(1'b1, 32'h0000_0600, 5'd8, 1'b1, 2'b00, 32'd1, 32'd0, 3'd0, 32'd0);
        step(K_NONE, 32'd0);
        @(negedge clk);
        #1;
        force dut.retire_q = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1;
        release dut.retire_q;
        @(posedge clk);
        #1;
        preload  = 1'b0;
        lit_kind = K_CNT;
        lit_val  = 32'd0;
        set_mem(1'b0, 32'h0000_0604, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 32'd0);
        step(K_CNT, 32'd1);

        // reset in the middle of a stall
        stall_in = 1'b1;
        flush_in = 1'b1;
        rst      = 1'b1;
        lit_kind = K_PC;
        lit_val  = RST_PC;
        #6;
        rst      = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;
        set_mem(1'b1, 32'h0000_0700, 5'd10, 1'b1, 2'b11, 32'd0, 32'hCAFE_0000, 3'd0, 32'd0);
        step(K_DATA, 32'hCAFE_0000);
        step(K_CNT, 32'd1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback stage of the pipelined RV32I core. It captures memory-stage results each cycle and extracts/extends load data. It drives the register file write port (`Wt_addr`/`Wt_data`/`RegWrite`) one cycle later and keeps a retired-instruction counter for the VGA debug display. It sits directly upstream of the register file; its write outputs also feed the forwarding unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: reset value of `wb_pc`.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_in`  in  1  hold the MEM/WB register (no capture, no retire count).
- `flush_in`  in  1  capture a bubble instead of MEM inputs.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_pc`  in  32  PC of the MEM instruction.
- `mem_rd`  in  5  destination register.
- `mem_reg_write`  in  1  instruction writes rd.
- `mem_wb_sel`  in  2  write source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- `mem_alu_result`  in  32  ALU result; for loads, the byte address.
- `mem_imm`  in  32  immediate (LUI).
- `mem_funct3`  in  3  load width/sign.
- `mem_rdata`  in  32  raw aligned word from data memory, valid in the MEM cycle.
- `Wt_addr`  out  5  register file write address.
- `Wt_data`  out  32  register file write data.
- `RegWrite`  out  1  register file write enable.
- `wb_valid`  out  1  WB stage holds a real instruction.
- `wb_pc`  out  32  PC of the WB instruction.
- `retired_count`  out  32  number of instructions retired.

## Operation
- Priority per posedge: `rst` > `stall_in` > `flush_in` > normal capture.
- **Stall:** every register holds, including `retired_count`.
- **Flush:** `wb_valid`=0, `RegWrite`=0, `Wt_addr`=0, `Wt_data`=0. `wb_pc` takes `mem_pc`.
- **Capture:**
  - `wb_valid` ← `mem_valid`; `wb_pc` ← `mem_pc`; `Wt_addr` ← `mem_rd`.
  - `RegWrite` ← `mem_valid & mem_reg_write & (mem_rd != 0)`.
  - `Wt_data` ← the selected source, computed combinationally from MEM inputs and registered:
    - 00: `mem_alu_result`.
    - 10: `mem_pc + 4`, mod 2^32.
    - 11: `mem_imm`.
    - 01: load extraction using `a = mem_alu_result[1:0]`:
      - 000 LB: `rdata[8a+7:8a]`, sign-extended.
      - 100 LBU: the same byte, zero-extended.
      - 001 LH: `rdata[16·a[1]+15:16·a[1]]`, sign-extended; `a[0]` ignored.
      - 101 LHU: the same halfword, zero-extended.
      - 010 LW, and any other funct3 (011, 110, 111): full `rdata`, low address bits ignored.
- **Retire:** `retired_count` increments by 1 on a posedge where `wb_valid`=1 and `stall_in`=0. It wraps 32'hFFFF_FFFF → 0.
- Bubbles (`wb_valid`=0) never assert `RegWrite` and never count.
- No writes to x0: `RegWrite` is forced 0 when rd=0, while `Wt_addr`/`Wt_data` are still captured.

## Timing
- Latency: MEM inputs sampled at posedge N appear on all outputs after posedge N. The register file commits them at posedge N+1.
- While stalled, outputs are held. The register file may rewrite the same value; this is harmless.
- Reset (asynchronous, immediate):
  - `Wt_addr`=0, `Wt_data`=0, `RegWrite`=0, `wb_valid`=0, `retired_count`=0.
  - `wb_pc`=`RESET_PC`.
- Reset asserted mid-stall or mid-flush overrides both. The first capture happens at the first posedge after `rst` falls.
- Simultaneous `stall_in` and `flush_in`: stall wins, state held.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** pulse `rst` mid-cycle with `RESET_PC`=32'h100 → all outputs 0 immediately, `wb_pc`=32'h100, `retired_count`=0.
- **Load extraction:** `mem_rdata`=32'h80FF_7F01, wb_sel=01, rd=5. Required `Wt_data` one cycle later, with `RegWrite`=1, `Wt_addr`=5:
  - LB a=1 → 32'h0000_007F.
  - LB a=3 → 32'hFFFF_FF80.
  - LBU a=2 → 32'h0000_00FF.
  - LH a=2 → 32'hFFFF_80FF.
  - LHU a=0 → 32'h0000_7F01.
  - LW a=3 → 32'h80FF_7F01.
- **Sources and x0:**
  - wb_sel=10, `mem_pc`=32'hFFFF_FFFC → `Wt_data`=0.
  - wb_sel=11, imm=32'h1234_5000 → 32'h1234_5000.
  - rd=0 with reg_write=1 → `RegWrite`=0, `retired_count` still +1.
- **Stall/flush:**
  - Capture instr A, then assert `stall_in` 3 cycles → outputs hold A, `retired_count` +1 total.
  - `stall_in`+`flush_in` together → still A.
  - `flush_in` alone → `wb_valid`=0, `RegWrite`=0, no count.
- **Counter wrap:** preload via 2^32−1 retirements (or a force of the counter in simulation), retire one more → `retired_count`=0.
- **Back-to-back with register file:** ADDI x1=5 then ADD x2=x1+x1 streamed every cycle → register file reads x1=5 via its write-through and x2=10.
